// File: rtl/key_repeat.sv
// key_repeat: turns a held push-button level into single-cycle increment pulses
//   (one after debounce, one after the initial hold delay, then one every RATE_CYCLES).
// Latency: first pulse DEBOUNCE_CYCLES+3 edges after sig rises (2 sync + 1 IDLE->DEBOUNCE).
// Backpressure: none; p is a fire-and-forget strobe, held flags an accepted hold.
// Ports:
//   clk   - rising-edge system clock
//   rst_n - asynchronous active-low reset
//   sig   - raw asynchronous key level, 1 = pressed
//   p     - registered single-cycle increment pulse
//   held  - registered, high while in DELAY/REPEAT
module key_repeat #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DELAY_CYCLES    = 20,
  parameter int RATE_CYCLES     = 5,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic p,
  output logic held
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    DELAY    = 2'd2,
    REPEAT   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(RATE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             sig_s;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             p_q, p_d;
  logic             held_q, held_d;

  assign sig_s = sync2_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = 1'b0;
    held_d  = held_q;

    if (state_q != IDLE && !sig_s) begin
      // Release is checked before any compare so it wins over a same-edge fire.
      state_d = IDLE;
      cnt_d   = '0;
      held_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          held_d = 1'b0;
          cnt_d  = '0;
          if (sig_s) begin
            state_d = DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (cnt_q == DEB_LAST) begin
            p_d     = 1'b1;
            held_d  = 1'b1;
            state_d = DELAY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        DELAY: begin
          if (cnt_q == DELAY_LAST) begin
            p_d     = 1'b1;
            state_d = REPEAT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        REPEAT: begin
          // With RATE_CYCLES==1 this fires every edge, so p stays high.
          if (cnt_q == RATE_LAST) begin
            p_d   = 1'b1;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          held_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
      p_q     <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      sync1_q <= sig;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      held_q  <= held_d;
    end
  end

  assign p    = p_q;
  assign held = held_q;

endmodule

// File: tb/tb_key_repeat.sv
// Directed bench for key_repeat with default parameters (D=4, L=20, R=5).
// Edge k of a window is the k-th rising edge after sig changed; outputs are
// sampled 1 ns after each edge and compared against hand-derived pulse masks.
module tb_key_repeat;

  logic clk;
  logic rst_n;
  logic sig;
  logic p;
  logic held;

  int checks;
  int failures;

  key_repeat #(
    .DEBOUNCE_CYCLES(4),
    .DELAY_CYCLES   (20),
    .RATE_CYCLES    (5),
    .CNT_W          (16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .sig  (sig),
    .p    (p),
    .held (held)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int k, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s edge=%0d observed=%b expected=%b", tag, k, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs n edges. sig is dropped right after edge fall_edge (<=0 means never).
  // p must be high exactly on edges set in pmask; held high for h_on <= k < h_off.
  task automatic run_edges(input string tag, input int n, input int fall_edge,
                           input logic [127:0] pmask, input int h_on, input int h_off);
    for (int k = 1; k <= n; k++) begin
      tick();
      chk({tag, "_p"}, k, p, pmask[k]);
      chk({tag, "_held"}, k, held, (k >= h_on) && (k < h_off));
      if (k == fall_edge) sig = 1'b0;
    end
  endtask

  logic [127:0] pm;

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    sig      = 1'b0;

    // Reset state.
    #3;
    chk("reset_p", 0, p, 1'b0);
    chk("reset_held", 0, held, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_p", 0, p, 1'b0);
    chk("idle_held", 0, held, 1'b0);

    // Scenario 1: press until the first pulse, then assert reset mid-cycle.
    sig = 1'b1;
    pm = '0; pm[7] = 1'b1;
    run_edges("s1_press", 7, 0, pm, 7, 1000);
    #2;
    rst_n = 1'b0;
    #1;
    chk("s1_async_p", 0, p, 1'b0);
    chk("s1_async_held", 0, held, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("s1_inrst_p", k, p, 1'b0);
      chk("s1_inrst_held", k, held, 1'b0);
    end
    sig = 1'b0;
    rst_n = 1'b1;
    tick();
    tick();

    // Scenario 2: glitch high for edges 1-3.
    sig = 1'b1;
    pm = '0;
    run_edges("s2_glitch", 10, 3, pm, 0, 0);

    // Scenario 3: short press, released after edge 10.
    sig = 1'b1;
    pm = '0; pm[7] = 1'b1;
    run_edges("s3_short", 16, 10, pm, 7, 13);

    // Scenario 4: long hold, released after edge 60.
    sig = 1'b1;
    pm = '0;
    pm[7] = 1'b1;  pm[27] = 1'b1; pm[32] = 1'b1; pm[37] = 1'b1; pm[42] = 1'b1;
    pm[47] = 1'b1; pm[52] = 1'b1; pm[57] = 1'b1; pm[62] = 1'b1;
    run_edges("s4_long", 66, 60, pm, 7, 63);

    // Scenario 5: release seen on the same edge the debounce would fire.
    sig = 1'b1;
    pm = '0;
    run_edges("s5_coinc", 10, 4, pm, 0, 0);

    // Scenario 6: hold into REPEAT, reset at edge 40 for 3 cycles, sig still high.
    sig = 1'b1;
    pm = '0; pm[7] = 1'b1; pm[27] = 1'b1; pm[32] = 1'b1; pm[37] = 1'b1;
    run_edges("s6_hold", 40, 0, pm, 7, 1000);
    rst_n = 1'b0;
    #1;
    chk("s6_async_p", 0, p, 1'b0);
    chk("s6_async_held", 0, held, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("s6_inrst_p", k, p, 1'b0);
      chk("s6_inrst_held", k, held, 1'b0);
    end
    rst_n = 1'b1;
    pm = '0; pm[7] = 1'b1; pm[27] = 1'b1;
    run_edges("s6_restart", 30, 0, pm, 7, 1000);
    sig = 1'b0;
    for (int k = 1; k <= 4; k++) tick();
    chk("s6_release_held", 4, held, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
